// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push/pop in the same cycle.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, stale-response dropping on
// redirect, and the decode-facing prefetch FIFO.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   LIMIT   = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d, ret_pc_q, ret_pc_d, tgt;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, fifo_count;
  logic          req_acc, rsp_take, keep, pop, fifo_full, fifo_empty, tgt_unused;
  fetch_entry_t  head, push_entry;

  assign tgt        = {redirect_target[31:2], 2'b00};
  assign tgt_unused = ^redirect_target[1:0];
  assign push_entry = '{pc: ret_pc_q, instr: imem_rsp_data};

  // Gated by rst_n so the request line is low while reset is held and rises
  // in the very first cycle after release.
  assign imem_req_valid = rst_n & (({1'b0, fifo_count} + {1'b0, outst_q}) < LIMIT);
  assign imem_req_addr  = fetch_pc_q;

  assign instr_valid    = ~fifo_empty;
  assign instr          = instr_valid ? head.instr : '0;
  assign instr_pc       = instr_valid ? head.pc : '0;
  assign instr_pc_plus4 = instr_pc + 32'd4;

  always_comb begin
    req_acc    = imem_req_valid & imem_req_ready;
    rsp_take   = imem_rsp_valid & (outst_q != '0);
    pop        = instr_valid & instr_ready;
    keep       = rsp_take & (drop_q == '0) & ~redirect;
    outst_d    = outst_q + CW'(req_acc) - CW'(rsp_take);
    drop_d     = (rsp_take && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    fetch_pc_d = req_acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    ret_pc_d   = keep ? ret_pc_q + 32'd4 : ret_pc_q;
    // Everything still in flight after this edge, including this cycle's accept, is stale.
    if (redirect) begin
      drop_d     = outst_d;
      fetch_pc_d = tgt;
      ret_pc_d   = tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      ret_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_outst_bound: assert property (@(posedge clk) disable iff (!rst_n) outst_q <= DEPTH_C);
  a_drop_bound:  assert property (@(posedge clk) disable iff (!rst_n) drop_q <= outst_q);
  a_rsp_orphan:  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && outst_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(keep && fifo_full && !pop));
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end: produces the instruction stream consumed by the decode/control stage.
- Consumes the branch/jump decision (PCsrc) and target back from decode/execute.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, prefetch FIFO entries; also the maximum number of outstanding memory requests (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; exactly one per accepted request, in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  returned instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes the head this cycle.
- instr  out  32  head instruction; 32'h0 when instr_valid=0.
- instr_pc  out  32  PC of the head instruction.
- instr_pc_plus4  out  32  instr_pc+4, used for the jalr link value.
- redirect  in  1  PCsrc: taken branch or jump.
- redirect_target  in  32  new PC.

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0; imem_req_valid=0; instr_valid=0; instr=0; instr_pc=0.
- First request is issued in the first cycle after rst_n deasserts. Reset mid-transfer discards everything; the memory must also be reset.
- Credit: imem_req_valid = (fifo_count + outstanding < DEPTH). imem_req_addr = fetch_pc.
- On request accept (valid & ready): fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- On response:
  - outstanding -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise push {pc, data} into the FIFO; pc comes from a return-PC register that is advanced by 4 per kept response.
- Response latency into the FIFO: data pushed at the edge is visible on instr the next cycle, i.e. no combinational rsp→instr path.
- Decode handshake: pop when instr_valid & instr_ready. Outputs are driven from the FIFO head. Push and pop in the same cycle are allowed when the FIFO is full or empty-with-push (count unchanged when full with pop).
- Redirect (highest priority, effective at the edge):
  - FIFO flushed.
  - fetch_pc and return-PC = {redirect_target[31:2],2'b00}.
  - drop = outstanding after this cycle's accept/response updates, i.e. all in-flight requests become stale, including a request accepted in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle still completes: it is the branch instruction itself.
- Request-channel contract: imem_req_addr is stable while valid & !ready, except in the cycle after a redirect, where the memory must accept an address change.
- Counter widths: $clog2(DEPTH+1). outstanding ≤ DEPTH and drop ≤ outstanding at all times; assertions cover both.
- imem_rsp_valid with outstanding==0 is a protocol error: assertion, response ignored.

Decomposition:
- fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
  - localparam NOP_INSTR = 32'h0000_0013 (bench filler).
  - Shared INSTR_W/ADDR_W = 32.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH, push/pop/flush, count, full/empty. The top level holds the PC, credit, drop logic and handshakes.

Test Plan:
- Reset with RESET_PC=0x100, memory always ready with 1-cycle latency, decode always ready → requests 0x100, 0x104, 0x108…; instr_pc follows the same sequence; instr_pc_plus4 = instr_pc+4; no bubbles after fill.
- Decode stalled (instr_ready=0), DEPTH=2 → at most 2 requests issued, then imem_req_valid=0; release → pop order intact and fetch resumes at 0x108.
- Redirect to 0x200 with 2 requests outstanding (3-cycle latency) → both responses dropped, FIFO empty, next instr_pc=0x200.
- Redirect to 0x203 in the same cycle as a request accept and a pop → accepted request dropped, pop completes, next fetch address 0x200.
- Random ready/latency plus random redirects over 10k cycles vs. a reference PC model → every delivered instr matches mem[instr_pc]; no loss or duplication; assertions hold.
- rst_n asserted mid-stream with 2 outstanding → outputs return to reset values immediately; fetch restarts at RESET_PC.
